// File: rtl/flash_prefetch_buffer.sv
// flash_prefetch_buffer: sequential prefetch window between the CPU
// fetch port and the flash_controller memory-mapped read port.
module flash_prefetch_buffer #(
    parameter int DEPTH     = 4,
    parameter int ADDR_BITS = 24
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic                 cpu_RD_ready,
    output logic                 cpu_RD_valid,
    output logic [31:0]          cpu_data_out,
    input  logic                 cpu_flush,
    output logic [ADDR_BITS-1:0] fl_addr,
    output logic                 fl_RD_ready,
    input  logic                 fl_RD_valid,
    input  logic [31:0]          fl_data_in
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [PW-1:0] ONE_P = PW'(1);
    localparam logic [ADDR_BITS-1:0] WSTEP = ADDR_BITS'(4);

    logic [0:0]           state_q, state_d;
    logic [ADDR_BITS-1:0] head_q, head_d;
    logic [ADDR_BITS-1:0] fl_addr_q, fl_addr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic                 active_q, active_d;
    logic                 stale_q, stale_d;
    logic                 fwd_q, fwd_d;
    logic                 valid_q, valid_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          win_q [DEPTH];

    logic [ADDR_BITS-1:0] req_addr, req_off, req_k;
    logic [PW-1:0]        wr_ptr, rd_idx;
    logic                 fl_done, accept, hit, arriving, push;
    logic                 unused_bits;

    assign req_addr = {cpu_addr[ADDR_BITS-1:2], 2'b00};
    assign req_off  = req_addr - head_q;
    assign req_k    = {2'b00, req_off[ADDR_BITS-1:2]};
    assign hit      = req_k < ADDR_BITS'(count_q);
    assign rd_idx   = rd_ptr_q + req_k[PW-1:0];
    assign wr_ptr   = rd_ptr_q + count_q[PW-1:0];
    assign fl_done  = (state_q == S_REQ) && fl_RD_valid;
    assign accept   = cpu_RD_ready && !valid_q && !fwd_q && !cpu_flush;
    assign arriving = (state_q == S_REQ) && !stale_q
                      && (fl_addr_q == req_addr);
    assign push     = fl_done && !stale_q && !fwd_q;

    assign unused_bits = ^{cpu_addr[1:0], req_off[1:0]};

    // Next-state: flash completion, CPU hit/miss, flush, then refill issue.
    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        fl_addr_d = fl_addr_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        active_d  = active_q;
        stale_d   = stale_q;
        fwd_d     = fwd_q;
        valid_d   = 1'b0;
        data_d    = data_q;

        if (fl_done) begin
            state_d = S_IDLE;
            if (stale_q) begin
                stale_d = 1'b0;
            end else if (fwd_q) begin
                valid_d = 1'b1;
                data_d  = fl_data_in;
                head_d  = head_q + WSTEP;
                fwd_d   = 1'b0;
            end else begin
                count_d = count_q + ONE_C;
            end
        end

        if (accept) begin
            if (hit) begin
                valid_d  = 1'b1;
                data_d   = win_q[rd_idx];
                rd_ptr_d = rd_idx + ONE_P;
                count_d  = count_d - (req_k[CW-1:0] + ONE_C);
                head_d   = req_addr + WSTEP;
            end else if (arriving) begin
                count_d = '0;
                if (fl_done) begin
                    valid_d = 1'b1;
                    data_d  = fl_data_in;
                    head_d  = req_addr + WSTEP;
                end else begin
                    head_d = req_addr;
                    fwd_d  = 1'b1;
                end
            end else begin
                count_d  = '0;
                head_d   = req_addr;
                active_d = 1'b1;
                fwd_d    = 1'b1;
                if ((state_q == S_REQ) && !fl_RD_valid) stale_d = 1'b1;
            end
        end

        if (cpu_flush) begin
            count_d  = '0;
            active_d = 1'b0;
            fwd_d    = 1'b0;
            valid_d  = 1'b0;
            if ((state_q == S_REQ) && !fl_RD_valid) stale_d = 1'b1;
        end

        if ((state_q == S_IDLE) && active_d && (count_d < FULL)) begin
            state_d   = S_REQ;
            fl_addr_d = head_d + ADDR_BITS'({count_d, 2'b00});
        end
    end

    // Control and address state with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            fl_addr_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            active_q  <= 1'b0;
            stale_q   <= 1'b0;
            fwd_q     <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            fl_addr_q <= fl_addr_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            active_q  <= active_d;
            stale_q   <= stale_d;
            fwd_q     <= fwd_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
        end
    end

    // Window storage; contents only meaningful under count_q.
    always_ff @(posedge CLK) begin
        if (push) win_q[wr_ptr] <= fl_data_in;
    end

    assign cpu_RD_valid = valid_q;
    assign cpu_data_out = data_q;
    assign fl_addr      = fl_addr_q;
    assign fl_RD_ready  = (state_q == S_REQ);
endmodule
